// File: rtl/axi_lite_apb_requester.sv
// axi_lite_apb_requester: AXI4-Lite slave front end that turns single-beat
// reads and writes into APB transfer requests, one transaction at a time.
//
// state  | meaning
// IDLE   | waiting for an AW+W pair or an AR
// ACCESS | apb_en held with a stable request, waiting for apb_ready or timeout
// RESP   | B or R response presented, waiting for the AXI ready
module axi_lite_apb_requester #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              apb_en,
  output logic [1:0]        apb_sel,
  output logic [4:0]        apb_addr,
  output logic              apb_write,
  output logic [31:0]       apb_wdata,
  input  logic [31:0]       apb_rdata,
  input  logic              apb_ready,
  input  logic              apb_error,
  output logic              busy
);

  // Down-counter loaded with TIMEOUT-1; terminal count reached on the
  // TIMEOUT-th ACCESS cycle without apb_ready.
  localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              rd_first;
  logic [TMR_W-1:0]  tmr;
  logic              wr_pend;
  logic              rd_pend;
  logic              wr_grant;
  logic              rd_grant;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_resp;
  logic              unused_addr;

  // Grant arbitration between AW+W and AR, and decode of the granted address
  always_comb begin
    wr_pend  = s_awvalid & s_wvalid;
    rd_pend  = s_arvalid;
    wr_grant = ~reset & (state == IDLE) & wr_pend & (~rd_pend | ~rd_first);
    rd_grant = ~reset & (state == IDLE) & rd_pend & (~wr_pend | rd_first);
    req_addr = wr_grant ? s_awaddr : s_araddr;
    if (req_addr[1:0] != 2'b00)
      req_resp = RESP_SLVERR;
    else if (req_addr[6])
      req_resp = RESP_DECERR;
    else if (wr_grant && (s_wstrb != 4'hF))
      req_resp = RESP_SLVERR;
    else
      req_resp = RESP_OKAY;
  end

  assign s_awready   = wr_grant;
  assign s_wready    = wr_grant;
  assign s_arready   = rd_grant;
  // Upper address bits take no part in decode.
  assign unused_addr = ^req_addr;

  // Transaction FSM with all APB request fields and AXI responses registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rd_first  <= 1'b0;
      tmr       <= '0;
      busy      <= 1'b0;
      apb_en    <= 1'b0;
      apb_sel   <= 2'b00;
      apb_addr  <= 5'd0;
      apb_write <= 1'b0;
      apb_wdata <= 32'd0;
      s_bvalid  <= 1'b0;
      s_bresp   <= 2'b00;
      s_rvalid  <= 1'b0;
      s_rresp   <= 2'b00;
      s_rdata   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_grant || rd_grant) begin
            busy <= 1'b1;
            if (wr_pend && rd_pend)
              rd_first <= ~rd_first;
            if (req_resp != RESP_OKAY) begin
              state <= RESP;
              if (wr_grant) begin
                s_bresp  <= req_resp;
                s_bvalid <= 1'b1;
              end else begin
                s_rresp  <= req_resp;
                s_rdata  <= 32'd0;
                s_rvalid <= 1'b1;
              end
            end else begin
              state     <= ACCESS;
              apb_en    <= 1'b1;
              apb_sel   <= req_addr[5] ? 2'b10 : 2'b01;
              apb_addr  <= req_addr[4:0];
              apb_write <= wr_grant;
              apb_wdata <= wr_grant ? s_wdata : 32'd0;
              tmr       <= TMR_LOAD;
            end
          end
        end
        ACCESS: begin
          if (apb_ready) begin
            apb_en <= 1'b0;
            state  <= RESP;
            if (apb_write) begin
              s_bresp  <= apb_error ? RESP_SLVERR : RESP_OKAY;
              s_bvalid <= 1'b1;
            end else begin
              s_rresp  <= apb_error ? RESP_SLVERR : RESP_OKAY;
              s_rdata  <= apb_rdata;
              s_rvalid <= 1'b1;
            end
          end else if ((TIMEOUT != 0) && (tmr == '0)) begin
            apb_en <= 1'b0;
            state  <= RESP;
            if (apb_write) begin
              s_bresp  <= RESP_SLVERR;
              s_bvalid <= 1'b1;
            end else begin
              s_rresp  <= RESP_SLVERR;
              s_rdata  <= 32'd0;
              s_rvalid <= 1'b1;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        RESP: begin
          if ((s_bvalid && s_bready) || (s_rvalid && s_rready)) begin
            s_bvalid <= 1'b0;
            s_rvalid <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
